// File: rtl/shot_sequencer.sv
// shot_sequencer: turns a fire click into a frame-aligned hit-test flash and reports hit/miss per shot.
// Optional macro SHOT_COOLDOWN_EN adds a COOL lockout of COOL_FRAMES frames after each non-final shot.
module shot_sequencer #(
  parameter int         AMMO         = 3,
  parameter int         FLASH_FRAMES = 1,
  parameter int         HIT_HALF     = 25,
  parameter logic [7:0] FIRE_CODE    = 8'd2
`ifdef SHOT_COOLDOWN_EN
  , parameter int       COOL_FRAMES  = 8
`endif
) (
  input  logic       vga_clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       blank,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [7:0] MouseButtons,
  input  logic       duck_px,
  input  logic       round_start,
  output logic       shot_on,
  output logic [1:0] shots_left,
  output logic       hit,
  output logic       miss,
  output logic       round_over,
  output logic       busy
);
`ifdef SHOT_COOLDOWN_EN
  typedef enum logic [2:0] {IDLE, ARMED, WAIT, FLASH, RESULT, DONE, COOL} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARMED, WAIT, FLASH, RESULT, DONE} state_t;
`endif
  localparam logic signed [10:0] HH = 11'(HIT_HALF);
  state_t state, state_d;
  logic fire_q, click, in_box, hit_acc, acc_d, hit_d, miss_d;
  logic [1:0] shots_d;
  logic [3:0] cnt, cnt_d;
  logic signed [10:0] dx, dy;
  assign click = (MouseButtons == FIRE_CODE) & ~fire_q;
  // zero-extended 11-bit signed differences keep a crosshair near the screen edge from wrapping
  assign dx = {1'b0, DrawX} - {1'b0, BallX};
  assign dy = {1'b0, DrawY} - {1'b0, BallY};
  assign in_box = (dx <= HH) && (dx >= -HH) && (dy <= HH) && (dy >= -HH);
  assign shot_on = state == FLASH;
  assign round_over = state == DONE;
  assign busy = !(state == ARMED || state == IDLE);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    acc_d = hit_acc;
    shots_d = shots_left;
    hit_d = 1'b0;
    miss_d = 1'b0;
    case (state)
      IDLE: ;
      ARMED: if (click && shots_left != 2'd0) state_d = WAIT;
      WAIT: begin
        cnt_d = '0;
        acc_d = 1'b0;
        if (frame_start) state_d = FLASH;
      end
      FLASH: begin
        acc_d = hit_acc | (blank & duck_px & in_box);
        cnt_d = cnt + 4'(frame_start);
        if (frame_start && cnt_d == 4'(FLASH_FRAMES)) state_d = RESULT;
      end
      RESULT: begin
        hit_d = hit_acc;
        miss_d = ~hit_acc;
        shots_d = shots_left - 2'd1;
        cnt_d = '0;
`ifdef SHOT_COOLDOWN_EN
        state_d = shots_d == 2'd0 ? DONE : COOL;
`else
        state_d = shots_d == 2'd0 ? DONE : ARMED;
`endif
      end
      DONE: ;
`ifdef SHOT_COOLDOWN_EN
      COOL: begin
        cnt_d = cnt + 4'(frame_start);
        if (frame_start && cnt_d == 4'(COOL_FRAMES)) state_d = ARMED;
      end
`endif
      default: state_d = IDLE;
    endcase
    // a new round overrides everything, including a shot still in flight
    if (round_start) begin
      state_d = ARMED;
      shots_d = 2'(AMMO);
      acc_d = 1'b0;
      hit_d = 1'b0;
      miss_d = 1'b0;
    end
  end
  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      fire_q <= 1'b0;
      cnt <= '0;
      hit_acc <= 1'b0;
      shots_left <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      state <= state_d;
      fire_q <= MouseButtons == FIRE_CODE;
      cnt <= cnt_d;
      hit_acc <= acc_d;
      shots_left <= shots_d;
      hit <= hit_d;
      miss <= miss_d;
    end
  end
endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: randomized frames against a frame-level shot model; results checked through a scoreboard queue.
module tb_shot_sequencer;
  localparam int N = 20, AMMO = 3, HH = 25, NF = 999, COOL = 8;
  localparam logic [7:0] FIRE = 8'd2;
  logic vga_clk = 0, Reset_n = 0, frame_start = 0, blank = 0, duck_px = 0, round_start = 0;
  logic [9:0] DrawX = 0, DrawY = 0, BallX = 320, BallY = 240;
  logic [7:0] MouseButtons = 0, cur_btn = 0;
  logic shot_on, hit, miss, round_over, busy;
  logic [1:0] shots_left;
  int checks = 0, errors = 0;
  typedef struct {logic h; logic [1:0] s;} res_t;
  res_t q[$];
  res_t e_mon;
  int ammo = 0, cool = 0, nbx = 320, nby = 240;
  bit active = 0, pending = 0, flashing = 0, acc = 0, prev_fire = 0, exp_shot = 0;

  shot_sequencer dut (
    .vga_clk(vga_clk), .Reset_n(Reset_n), .frame_start(frame_start), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY),
    .MouseButtons(MouseButtons), .duck_px(duck_px), .round_start(round_start),
    .shot_on(shot_on), .shots_left(shots_left), .hit(hit), .miss(miss),
    .round_over(round_over), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_shot_on"}, int'(shot_on), 0);
    chk({tag, "_shots_left"}, int'(shots_left), 0);
    chk({tag, "_hit"}, int'(hit), 0);
    chk({tag, "_miss"}, int'(miss), 0);
    chk({tag, "_round_over"}, int'(round_over), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // monitor: every result pulse consumes one expected shot outcome
  always @(negedge vga_clk) begin
    if (hit || miss) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got hit=%0b miss=%0b expected no pulse", hit, miss);
      end else begin
        e_mon = q.pop_front();
        chk("hit", int'(hit), int'(e_mon.h));
        chk("miss", int'(miss), int'(!e_mon.h));
        chk("shots_left", int'(shots_left), int'(e_mon.s));
      end
    end
  end

  // one clock: check previous outputs, apply inputs, advance the frame-level model
  task automatic cyc(input bit fs, input bit bl, input int x, input int y, input bit dk,
                     input logic [7:0] btn, input bit rs, input bit tail);
    bit fire, click, can;
    @(posedge vga_clk); #1;
    chk("shot_on", int'(shot_on), int'(exp_shot));
    if (tail) begin
      chk("round_over", int'(round_over), int'(active && ammo == 0 && !pending && !flashing));
      chk("busy", int'(busy), int'(active && (pending || flashing || cool > 0 || ammo == 0)));
    end
    if (fs) begin
      BallX = 10'(nbx);
      BallY = 10'(nby);
    end
    frame_start = fs; blank = bl; DrawX = 10'(x); DrawY = 10'(y);
    duck_px = dk; MouseButtons = btn; round_start = rs;
    fire = btn == FIRE;
    click = fire && !prev_fire;
    prev_fire = fire;
    can = active && ammo > 0 && !pending && !flashing && cool == 0;
    if (flashing && bl && dk && iabs(x - int'(BallX)) <= HH && iabs(y - int'(BallY)) <= HH) acc = 1;
    if (fs) begin
      if (cool > 0) cool--;
      if (flashing) begin
        flashing = 0;
        ammo--;
        q.push_back('{acc, 2'(ammo)});
`ifdef SHOT_COOLDOWN_EN
        if (ammo > 0) cool = COOL;
`endif
      end else if (pending) begin
        pending = 0;
        flashing = 1;
        acc = 0;
      end
    end
    if (click && can) pending = 1;
    if (rs) begin
      active = 1; ammo = AMMO; pending = 0; flashing = 0; acc = 0; cool = 0;
    end
    exp_shot = flashing;
  endtask

  function automatic int clamp(input int v);
    return v < 0 ? 0 : (v > 1023 ? 1023 : v);
  endfunction

  // press_at: -1 random button activity, -2 none, >=0 directed click; fdx: forced single duck pixel offset
  task automatic frame(input int rs_at, input int press_at, input int fdx, input int bx, input int rst_at);
    int rel, p, code, x, y;
    bit dk, bl;
    rel = -1; p = -1; code = 2;
    nbx = bx > 0 ? bx : ($urandom_range(0, 3) == 0 ? 10 : int'($urandom_range(30, 600)));
    nby = $urandom_range(0, 3) == 0 ? 5 : int'($urandom_range(30, 440));
    if (press_at == -1) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin p = $urandom_range(3, 15); rel = p + int'($urandom_range(1, 3)); end
        5: p = $urandom_range(3, 15);
        6: rel = $urandom_range(3, N - 1);
        7: begin p = $urandom_range(3, 15); rel = p + 2; code = 1; end
        default: ;
      endcase
    end else if (press_at >= 0) begin
      p = press_at;
      rel = p + 2;
    end
    for (int c = 0; c < N; c++) begin
      if (c == p) cur_btn = 8'(code);
      if (c == rel) cur_btn = 8'd0;
      bl = c > 0 && c < N - 1;
      if (fdx != NF) begin
        x = c == 10 ? clamp(nbx + fdx) : nbx;
        y = nby;
        dk = c == 10;
      end else begin
        x = clamp(nbx + int'($urandom_range(0, 56)) - 28);
        y = clamp(nby + int'($urandom_range(0, 56)) - 28);
        dk = $urandom_range(0, 15) == 0;
      end
      if (c == rst_at) begin
        @(posedge vga_clk); #1;
        chk("shot_on_pre_reset", int'(shot_on), int'(exp_shot));
        Reset_n = 0;
        #1;
        rst_chk("async_reset");
        active = 0; ammo = 0; pending = 0; flashing = 0; acc = 0; cool = 0;
        exp_shot = 0; prev_fire = 0; cur_btn = 0; MouseButtons = 0;
        return;
      end
      cyc(c == 0, bl, x, y, dk, cur_btn, c == rs_at, c == N - 1);
    end
  endtask

  initial begin
    Reset_n = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    rst_chk("reset");
    Reset_n = 1;
    frame(4, 8, NF, 0, -1);
    frame(-1, -2, 25, 0, -1);
    frame(-1, 8, NF, 0, -1);
    frame(-1, -2, 26, 0, -1);
    frame(-1, 8, NF, 0, -1);
    frame(-1, -2, -10, 10, -1);
    frame(-1, -2, NF, 0, -1);
    frame(-1, 8, NF, 0, -1);
    frame(-1, -2, NF, 0, -1);
    frame(4, -2, NF, 0, -1);
    repeat (300) frame($urandom_range(0, 11) == 0 ? int'($urandom_range(4, N - 1)) : -1, -1, NF, 0, -1);
    frame(4, 8, NF, 0, -1);
    frame(-1, -2, NF, 0, 10);
    repeat (3) @(posedge vga_clk);
    #1;
    rst_chk("held_reset");
    Reset_n = 1;
    repeat (4) cyc(0, 0, 0, 0, 0, 8'd0, 0, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
